// File: rtl/pipeline_hazard_unit_pkg.sv
// Shared types for the pipeline hazard unit: forwarding selects, FSM states, default widths.
package pipeline_hazard_unit_pkg;

  localparam int REG_W_DEF = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_EX  = 2'b01,
    FWD_MEM = 2'b10,
    FWD_WB  = 2'b11
  } fwd_e;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

endpackage

// File: rtl/pipeline_hazard_unit_if.sv
// Pipeline-register field taps and hazard controls; HAZ_PERF_CNT_EN adds the stall/flush counters.
interface pipeline_hazard_unit_if #(parameter int REG_W = 5);
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [REG_W-1:0] ex_rd;
  logic             ex_rf_we;
  logic             ex_load;
  logic [REG_W-1:0] mem_rd;
  logic             mem_rf_we;
  logic [REG_W-1:0] wb_rd;
  logic             wb_rf_we;
  logic             annul_req;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic             stall;
  logic             bubble_id_ex;
  logic             flush_if_id;
  logic             busy;
`ifdef HAZ_PERF_CNT_EN
  logic [15:0]      stall_cnt;
  logic [15:0]      flush_cnt;
`endif

  modport master (
`ifdef HAZ_PERF_CNT_EN
    input  stall_cnt, flush_cnt,
`endif
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_rf_we, ex_load,
    output mem_rd, mem_rf_we, wb_rd, wb_rf_we, annul_req,
    input  fwd_a, fwd_b, stall, bubble_id_ex, flush_if_id, busy
  );

  modport slave (
`ifdef HAZ_PERF_CNT_EN
    output stall_cnt, flush_cnt,
`endif
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_rf_we, ex_load,
    input  mem_rd, mem_rf_we, wb_rd, wb_rf_we, annul_req,
    output fwd_a, fwd_b, stall, bubble_id_ex, flush_if_id, busy
  );
endinterface

// File: rtl/pipeline_hazard_unit_fwd_sel.sv
// Per-operand forwarding priority selector (EX > MEM > WB > regfile); flags load-use on an EX load match.
module hazard_fwd_sel
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int REG_W = REG_W_DEF
) (
  input  logic [REG_W-1:0] src,
  input  logic             src_used,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_rf_we,
  input  logic             ex_load,
  input  logic [REG_W-1:0] mem_rd,
  input  logic             mem_rf_we,
  input  logic [REG_W-1:0] wb_rd,
  input  logic             wb_rf_we,
  output fwd_e             fwd,
  output logic             luh
);

  logic ex_hit, mem_hit, wb_hit;

  // %g0 is hardwired, so a write to it never creates a dependency
  assign ex_hit  = src_used & ex_rf_we  & (ex_rd  == src) & (ex_rd  != '0);
  assign mem_hit = src_used & mem_rf_we & (mem_rd == src) & (mem_rd != '0);
  assign wb_hit  = src_used & wb_rf_we  & (wb_rd  == src) & (wb_rd  != '0);

  always_comb begin
    fwd = FWD_RF;
    luh = 1'b0;
    if (ex_hit) begin
      if (ex_load) luh = 1'b1;
      else         fwd = FWD_EX;
    end else if (mem_hit) begin
      fwd = FWD_MEM;
    end else if (wb_hit) begin
      fwd = FWD_WB;
    end
  end

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Pipeline hazard unit: forwarding, load-use stall sequencing and delay-slot annul.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush cycle counters.
module pipeline_hazard_unit
  import pipeline_hazard_unit_pkg::*;
#(
  parameter int REG_W             = REG_W_DEF,
  parameter int LOAD_STALL_CYCLES = 1
) (
  input logic                  Clk,
  input logic                  reset,
  pipeline_hazard_unit_if.slave bus
);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       annul_pend_q, annul_pend_d;
  fwd_e       sel_a, sel_b, fwd_a, fwd_b;
  logic       luh_a, luh_b;
  logic       stall, bubble, flush;

  hazard_fwd_sel #(.REG_W(REG_W)) u_sel_a (
    .src(bus.id_rs1), .src_used(bus.id_rs1_used),
    .ex_rd(bus.ex_rd), .ex_rf_we(bus.ex_rf_we), .ex_load(bus.ex_load),
    .mem_rd(bus.mem_rd), .mem_rf_we(bus.mem_rf_we),
    .wb_rd(bus.wb_rd), .wb_rf_we(bus.wb_rf_we),
    .fwd(sel_a), .luh(luh_a)
  );

  hazard_fwd_sel #(.REG_W(REG_W)) u_sel_b (
    .src(bus.id_rs2), .src_used(bus.id_rs2_used),
    .ex_rd(bus.ex_rd), .ex_rf_we(bus.ex_rf_we), .ex_load(bus.ex_load),
    .mem_rd(bus.mem_rd), .mem_rf_we(bus.mem_rf_we),
    .wb_rd(bus.wb_rd), .wb_rf_we(bus.wb_rf_we),
    .fwd(sel_b), .luh(luh_b)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    annul_pend_d = annul_pend_q;
    stall        = 1'b0;
    bubble       = 1'b0;
    flush        = 1'b0;
    fwd_a        = FWD_RF;
    fwd_b        = FWD_RF;

    case (state_q)
      RUN: begin
        if (luh_a | luh_b) begin
          stall  = 1'b1;
          bubble = 1'b1;
          if (LOAD_STALL_CYCLES > 1) begin
            state_d = STALL;
            cnt_d   = 3'(LOAD_STALL_CYCLES - 1);
          end
        end else begin
          fwd_a = sel_a;
          fwd_b = sel_b;
        end
      end
      STALL: begin
        stall  = 1'b1;
        bubble = 1'b1;
        cnt_d  = cnt_q - 3'd1;
        if (cnt_q == 3'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase

    // IF/ID is held during a stall, so a flush there would be lost; defer it
    if (stall) begin
      if (bus.annul_req) annul_pend_d = 1'b1;
    end else begin
      flush        = bus.annul_req | annul_pend_q;
      annul_pend_d = 1'b0;
    end

    if (reset) begin
      stall  = 1'b0;
      bubble = 1'b0;
      flush  = 1'b0;
      fwd_a  = FWD_RF;
      fwd_b  = FWD_RF;
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      state_q      <= RUN;
      cnt_q        <= 3'd0;
      annul_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      annul_pend_q <= annul_pend_d;
    end
  end

  assign bus.fwd_a        = fwd_a;
  assign bus.fwd_b        = fwd_b;
  assign bus.stall        = stall;
  assign bus.bubble_id_ex = bubble;
  assign bus.flush_if_id  = flush;
  assign bus.busy         = (state_q != RUN) & ~reset;

`ifdef HAZ_PERF_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
    if (flush && flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      stall_cnt_q <= 16'd0;
      flush_cnt_q <= 16'd0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.stall_cnt = stall_cnt_q;
  assign bus.flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Directed bench for pipeline_hazard_unit: one instance with 1-cycle load stall, one with 3.
module tb_pipeline_hazard_unit;
  import pipeline_hazard_unit_pkg::*;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic [4:0] ex_rd;
    logic       ex_we;
    logic       ex_ld;
    logic [4:0] mem_rd;
    logic       mem_we;
    logic [4:0] wb_rd;
    logic       wb_we;
    logic       annul;
  } in_t;

  localparam in_t IDLE = '0;

  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;

  always #5 clk = ~clk;

  pipeline_hazard_unit_if #(.REG_W(5)) b1 ();
  pipeline_hazard_unit_if #(.REG_W(5)) b3 ();

  pipeline_hazard_unit #(.REG_W(5), .LOAD_STALL_CYCLES(1)) u1 (.Clk(clk), .reset(reset), .bus(b1));
  pipeline_hazard_unit #(.REG_W(5), .LOAD_STALL_CYCLES(3)) u3 (.Clk(clk), .reset(reset), .bus(b3));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic apply(input int which, input in_t v);
    if (which == 1) begin
      b1.id_rs1 = v.rs1; b1.id_rs2 = v.rs2; b1.id_rs1_used = v.u1; b1.id_rs2_used = v.u2;
      b1.ex_rd = v.ex_rd; b1.ex_rf_we = v.ex_we; b1.ex_load = v.ex_ld;
      b1.mem_rd = v.mem_rd; b1.mem_rf_we = v.mem_we;
      b1.wb_rd = v.wb_rd; b1.wb_rf_we = v.wb_we; b1.annul_req = v.annul;
    end else begin
      b3.id_rs1 = v.rs1; b3.id_rs2 = v.rs2; b3.id_rs1_used = v.u1; b3.id_rs2_used = v.u2;
      b3.ex_rd = v.ex_rd; b3.ex_rf_we = v.ex_we; b3.ex_load = v.ex_ld;
      b3.mem_rd = v.mem_rd; b3.mem_rf_we = v.mem_we;
      b3.wb_rd = v.wb_rd; b3.wb_rf_we = v.wb_we; b3.annul_req = v.annul;
    end
  endtask

  // Advance to the next negedge (one posedge in between), then let comb logic settle.
  task automatic next_cyc();
    @(negedge clk);
    #1;
  endtask

  //                          rs1    rs2    u1    u2    ex_rd  we    ld    mem_rd we    wb_rd  we    annul
  localparam in_t EX5     = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0};
  localparam in_t EX5_AN  = '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1};
  localparam in_t RS1_0   = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd5,  1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0};
  localparam in_t G0_WR   = '{5'd0, 5'd0, 1'b1, 1'b0, 5'd0,  1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0};
  localparam in_t UNUSED  = '{5'd5, 5'd0, 1'b0, 1'b0, 5'd5,  1'b1, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0};
  localparam in_t PRI_ALL = '{5'd0, 5'd7, 1'b0, 1'b1, 5'd7,  1'b1, 1'b0, 5'd7,  1'b1, 5'd7,  1'b1, 1'b0};
  localparam in_t PRI_MEM = '{5'd0, 5'd7, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 5'd7,  1'b1, 5'd7,  1'b1, 1'b0};
  localparam in_t PRI_WB  = '{5'd0, 5'd7, 1'b0, 1'b1, 5'd7,  1'b0, 1'b0, 5'd7,  1'b0, 5'd7,  1'b1, 1'b0};
  localparam in_t LUH3    = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd3,  1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0};
  localparam in_t LUH3_B  = '{5'd0, 5'd3, 1'b0, 1'b1, 5'd3,  1'b1, 1'b1, 5'd0,  1'b0, 5'd0,  1'b0, 1'b0};
  localparam in_t MEM3    = '{5'd3, 5'd0, 1'b1, 1'b0, 5'd0,  1'b0, 1'b0, 5'd3,  1'b1, 5'd0,  1'b0, 1'b0};
  localparam in_t ANNUL   = '{5'd0, 5'd0, 1'b0, 1'b0, 5'd0,  1'b0, 1'b0, 5'd0,  1'b0, 5'd0,  1'b0, 1'b1};

  initial begin
    reset = 1'b1;
    apply(1, EX5_AN);
    apply(3, LUH3);
    next_cyc();
    chk("rst_fwd_a",  32'(b1.fwd_a), 32'd0);
    chk("rst_flush",  32'(b1.flush_if_id), 32'd0);
    chk("rst_stall",  32'(b3.stall), 32'd0);
    chk("rst_bubble", 32'(b3.bubble_id_ex), 32'd0);
    chk("rst_busy",   32'(b3.busy), 32'd0);
    next_cyc();
    chk("rst_busy_2", 32'(b3.busy), 32'd0);

    reset = 1'b0;
    apply(1, EX5);
    apply(3, IDLE);
    #1;
    chk("fwd_ex",       32'(b1.fwd_a), 32'(FWD_EX));
    chk("fwd_ex_stall", 32'(b1.stall), 32'd0);
    apply(1, RS1_0);  #1; chk("fwd_rs1_g0",  32'(b1.fwd_a), 32'(FWD_RF));
    apply(1, G0_WR);  #1; chk("fwd_g0_wr",   32'(b1.fwd_a), 32'(FWD_RF));
    apply(1, UNUSED); #1; chk("fwd_unused",  32'(b1.fwd_a), 32'(FWD_RF));

    apply(1, PRI_ALL); #1; chk("pri_ex",  32'(b1.fwd_b), 32'(FWD_EX));
    chk("pri_ex_a", 32'(b1.fwd_a), 32'(FWD_RF));
    apply(1, PRI_MEM); #1; chk("pri_mem", 32'(b1.fwd_b), 32'(FWD_MEM));
    apply(1, PRI_WB);  #1; chk("pri_wb",  32'(b1.fwd_b), 32'(FWD_WB));

    // annul with no stall: same-cycle flush, one cycle only
    apply(1, ANNUL); #1;
    chk("annul_flush", 32'(b1.flush_if_id), 32'd1);
    next_cyc();
    apply(1, IDLE); #1;
    chk("annul_once", 32'(b1.flush_if_id), 32'd0);

    // load-use, one stall cycle, then MEM forwarding
    apply(1, LUH3_B); #1;
    chk("luh1_stall",  32'(b1.stall), 32'd1);
    chk("luh1_bubble", 32'(b1.bubble_id_ex), 32'd1);
    chk("luh1_fwd_b",  32'(b1.fwd_b), 32'(FWD_RF));
    chk("luh1_busy",   32'(b1.busy), 32'd0);
    next_cyc();
    apply(1, MEM3); #1;
    chk("luh1_release", 32'(b1.stall), 32'd0);
    chk("luh1_bub_off", 32'(b1.bubble_id_ex), 32'd0);
    chk("luh1_fwd_mem", 32'(b1.fwd_a), 32'(FWD_MEM));

    // load-use with three stall cycles and an annul in the second
    apply(3, LUH3); #1;
    chk("luh3_c0_stall", 32'(b3.stall), 32'd1);
    chk("luh3_c0_busy",  32'(b3.busy), 32'd0);
    next_cyc();
    apply(3, '{5'd5, 5'd0, 1'b1, 1'b0, 5'd5, 1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1}); #1;
    chk("luh3_c1_stall", 32'(b3.stall), 32'd1);
    chk("luh3_c1_busy",  32'(b3.busy), 32'd1);
    chk("luh3_c1_fwd",   32'(b3.fwd_a), 32'(FWD_RF));
    chk("luh3_c1_flush", 32'(b3.flush_if_id), 32'd0);
    next_cyc();
    apply(3, IDLE); #1;
    chk("luh3_c2_stall",  32'(b3.stall), 32'd1);
    chk("luh3_c2_bubble", 32'(b3.bubble_id_ex), 32'd1);
    chk("luh3_c2_busy",   32'(b3.busy), 32'd1);
    chk("luh3_c2_flush",  32'(b3.flush_if_id), 32'd0);
    next_cyc();
    chk("luh3_c3_stall", 32'(b3.stall), 32'd0);
    chk("luh3_c3_busy",  32'(b3.busy), 32'd0);
    chk("luh3_c3_flush", 32'(b3.flush_if_id), 32'd1);
    next_cyc();
    chk("luh3_c4_flush", 32'(b3.flush_if_id), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("perf_stall_cnt", 32'(b3.stall_cnt), 32'd3);
    chk("perf_flush_cnt", 32'(b3.flush_cnt), 32'd1);
`endif

    // reset during a stall with an annul pending
    apply(3, LUH3); #1;
    chk("rms_c0_stall", 32'(b3.stall), 32'd1);
    next_cyc();
    apply(3, ANNUL); #1;
    chk("rms_c1_busy", 32'(b3.busy), 32'd1);
    next_cyc();
    apply(3, IDLE);
    reset = 1'b1; #1;
    chk("rms_rst_stall", 32'(b3.stall), 32'd0);
    next_cyc();
    reset = 1'b0; #1;
    chk("rms_after_stall",  32'(b3.stall), 32'd0);
    chk("rms_after_busy",   32'(b3.busy), 32'd0);
    chk("rms_after_bubble", 32'(b3.bubble_id_ex), 32'd0);
    chk("rms_after_flush",  32'(b3.flush_if_id), 32'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("perf_stall_rst", 32'(b3.stall_cnt), 32'd0);
    chk("perf_flush_rst", 32'(b3.flush_cnt), 32'd0);
`endif
    next_cyc();
    chk("rms_no_late_flush", 32'(b3.flush_if_id), 32'd0);
    chk("rms_no_late_busy",  32'(b3.busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
